// File: rtl/mdu_hilo.sv
// Iterative MIPS32 multiply/divide unit with HI/LO result registers and a start/busy/done handshake.
// Optional build macro MDU_FAST_MUL_EN: single-cycle multiply, divide stays iterative.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// RUN   | one shift-add / restoring-divide step per clock
// FIN   | sign correction; hi/lo and done land at the closing edge
module mdu_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_next;
    logic               load, step, fin;

    logic               is_div_q;
    logic               sgn_a_q, sgn_b_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   rs_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               neg_rs, neg_rt;
    logic [WIDTH-1:0]   abs_rs, abs_rt;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] div_step;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, abs_rs} * {{WIDTH{1'b0}}, abs_rt};
`endif

    // Operand magnitudes; the most negative value maps onto itself, which the unsigned core handles.
    assign neg_rs = ~op[0] & rs_data[WIDTH-1];
    assign neg_rt = ~op[0] & rt_data[WIDTH-1];
    assign abs_rs = neg_rs ? -rs_data : rs_data;
    assign abs_rt = neg_rt ? -rt_data : rt_data;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Borrow out of the trial subtraction selects restore versus keep.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff     = rem_sh - {1'b0, opnd_q};
    assign div_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = (sgn_a_q ^ sgn_b_q) ? -acc_q : acc_q;
    assign quo_fix  = (sgn_a_q ^ sgn_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = sgn_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (opnd_q == '0) begin
                res_hi = rs_q;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        fin        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
`ifdef MDU_FAST_MUL_EN
                    state_next = op[1] ? RUN : FIN;
`else
                    state_next = RUN;
`endif
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == CNT_LAST) state_next = FIN;
            end
            FIN: begin
                fin        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div_q <= 1'b0;
            sgn_a_q  <= 1'b0;
            sgn_b_q  <= 1'b0;
            opnd_q   <= '0;
            rs_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            is_div_q <= op[1];
            sgn_a_q  <= neg_rs;
            sgn_b_q  <= neg_rt;
            rs_q     <= rs_data;
            cnt_q    <= '0;
            if (op[1]) begin
                opnd_q <= abs_rt;
                acc_q  <= {{WIDTH{1'b0}}, abs_rs};
            end else begin
                opnd_q <= abs_rs;
`ifdef MDU_FAST_MUL_EN
                acc_q  <= fast_prod;
`else
                acc_q  <= {{WIDTH{1'b0}}, abs_rt};
`endif
            end
        end else if (step) begin
            acc_q <= is_div_q ? div_step : mul_step;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Result write has priority; MTHI/MTLO only land while no operation is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fin;
            if (fin) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state == IDLE) begin
                if (hi_we) hi_q <= wr_data;
                if (lo_we) lo_q <= wr_data;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
